// File: rtl/btn_if.sv
// btn_if: raw pushbutton levels in, conditioned levels and event pulses out (raw, level, press, release, long, repeat)
interface btn_if #(parameter int N_BTN = 5);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_repeat;
  modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_long, btn_repeat);
  modport slave (input btn_raw, output btn_level, btn_press, btn_release, btn_long, btn_repeat);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button sync, debounce, press/release/long/auto-repeat pulses (clk, reset, bus: btn_if slave; BTN_AUTOREPEAT_EN enables btn_repeat)
module btn_conditioner #(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input logic clk,
  input logic reset,
  btn_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_END = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] H_PRE = HW'(HOLD_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] R_END = RW'(REPEAT_CYCLES - 1);
`endif
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_conditioner: cycle parameters must be at least 1");
  end
  for (genvar g = 0; g < N_BTN; g++) begin : g_bit
    logic s1_q, s2_q, lvl_q, prs_q, rls_q, lng_q;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hd_q, hd_d;
    logic diff, tog, stay, lng_d;
    // tog: the synchronized level has differed for DEBOUNCE_CYCLES cycles; stay: level is 1 and remains 1
    always_comb begin
      diff = s2_q ^ lvl_q;
      tog = diff && db_q == DB_END;
      stay = lvl_q && !tog;
      db_d = (!diff || tog) ? '0 : db_q + 1'b1;
      hd_d = !lvl_q ? '0 : hd_q == H_END ? hd_q : hd_q + 1'b1;
      lng_d = stay && hd_q == H_PRE;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        {s1_q, s2_q, lvl_q, prs_q, rls_q, lng_q} <= '0;
        db_q <= '0;
        hd_q <= '0;
      end else begin
        s1_q <= bus.btn_raw[g];
        s2_q <= s1_q;
        lvl_q <= lvl_q ^ tog;
        prs_q <= tog && !lvl_q;
        rls_q <= tog && lvl_q;
        lng_q <= lng_d;
        db_q <= db_d;
        hd_q <= hd_d;
      end
    end
    assign bus.btn_level[g] = lvl_q;
    assign bus.btn_press[g] = prs_q;
    assign bus.btn_release[g] = rls_q;
    assign bus.btn_long[g] = lng_q;
`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0] rp_q, rp_d;
    logic rpt_q, rpt_d;
    // The repeat interval only runs once the hold counter has saturated (after the long-press)
    always_comb begin
      rp_d = (!lvl_q || hd_q != H_END || rp_q == R_END) ? '0 : rp_q + 1'b1;
      rpt_d = (tog && !lvl_q) || lng_d || (stay && hd_q == H_END && rp_q == R_END);
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        rp_q <= '0;
        rpt_q <= 1'b0;
      end else begin
        rp_q <= rp_d;
        rpt_q <= rpt_d;
      end
    end
    assign bus.btn_repeat[g] = rpt_q;
`else
    assign bus.btn_repeat[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner (expected pulses queued at stimulus time, matched at the outputs)
module tb_btn_conditioner;
  localparam int N = 5, DB = 4, HC = 20, RC = 5;
  typedef struct {int cyc; int kind; int b;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  ev_t exp_q[$];
  string kn[4] = '{"press", "release", "long", "repeat"};
  btn_if #(.N_BTN(N)) bif();
  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic push(input int c, input int k, input int b);
    exp_q.push_back('{c, k, b});
  endtask
  task automatic push_hold(input int b, input int p, input int r);
    push(p, 0, b);
    push(r, 1, b);
    if (p + HC < r) push(p + HC, 2, b);
`ifdef BTN_AUTOREPEAT_EN
    push(p, 3, b);
    if (p + HC < r) push(p + HC, 3, b);
    for (int t = p + HC + RC; t < r; t += RC) push(t, 3, b);
`endif
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [N-1:0] kv(input int k);
    return k == 0 ? bif.btn_press : k == 1 ? bif.btn_release : k == 2 ? bif.btn_long : bif.btn_repeat;
  endfunction
  function automatic logic [31:0] all_out();
    return {7'd0, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat};
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        logic [N-1:0] v;
        v = kv(k);
        for (int b = 0; b < N; b++) begin
          if (v[b]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
              if (idx < 0 && exp_q[i].kind == k && exp_q[i].b == b) idx = i;
            if (idx < 0) check($sformatf("unexpected_%s[%0d]@%0d", kn[k], b, cyc), 1, 0);
            else begin
              check($sformatf("%s[%0d]_cycle", kn[k], b), cyc, exp_q[idx].cyc);
              exp_q.delete(idx);
            end
          end
        end
      end
    end
  end
  initial begin
    int c;
    bif.btn_raw = '0;
    step(3);
    check("reset_outputs", all_out(), 0);
    reset = 1'b0;
    step(2);
    c = cyc;
    bif.btn_raw[0] = 1'b1;
    push_hold(0, c + 6, c + 46);
    step(5);
    check("level0_before", bif.btn_level[0], 0);
    step(1);
    check("level0_rise", bif.btn_level[0], 1);
    step(34);
    bif.btn_raw[0] = 1'b0;
    step(15);
    for (int n = 0; n < 5; n++) begin
      bif.btn_raw[2] = 1'b1;
      step(3);
      bif.btn_raw[2] = 1'b0;
      step(2);
    end
    step(10);
    check("glitch_level2", bif.btn_level[2], 0);
    c = cyc;
    bif.btn_raw[1] = 1'b1;
    bif.btn_raw[3] = 1'b1;
    push_hold(1, c + 6, c + 16);
    push_hold(3, c + 6, c + 16);
    step(10);
    bif.btn_raw[1] = 1'b0;
    bif.btn_raw[3] = 1'b0;
    step(12);
    c = cyc;
    bif.btn_raw[4] = 1'b1;
    push_hold(4, c + 6, c + 46);
    step(40);
    bif.btn_raw[4] = 1'b0;
    step(12);
    c = cyc;
    bif.btn_raw[0] = 1'b1;
    push(c + 6, 0, 0);
    step(16);
    reset = 1'b1;
    step(3);
    check("midreset_outputs", all_out(), 0);
    reset = 1'b0;
    push_hold(0, c + 25, c + 51);
    step(5);
    check("after_reset_level0", bif.btn_level[0], 0);
    step(1);
    check("after_reset_rise0", bif.btn_level[0], 1);
    step(20);
    bif.btn_raw[0] = 1'b0;
    step(20);
    check("final_levels", bif.btn_level, 0);
    foreach (exp_q[i]) check($sformatf("missing_%s[%0d]@%0d", kn[exp_q[i].kind], exp_q[i].b, exp_q[i].cyc), 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
